cycle_step_ctrl: RTL and testbench

//  Clock-enable controller for procesadorArm; successor to the fixed clk_step/clk_select scheme.

---
 rtl/cycle_step_pkg.sv | 34 +++
 rtl/step_debounce.sv | 60 ++++++
 rtl/cycle_step_ctrl.sv | 161 ++++++++++++++++
 tb/tb_cycle_step_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cycle_step_pkg.sv
// Shared types for the procesadorArm clock-enable controller.
// The BREAK state exists only when STEP_BREAKPOINT_EN is defined.
package cycle_step_pkg;

    localparam int CYC_CNT_W = 32;

    typedef enum logic [1:0] {
        MODE_HALT  = 2'b00,
        MODE_RUN   = 2'b01,
        MODE_STEP  = 2'b10,
        MODE_BURST = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_STEP,
        ST_BURST
`ifdef STEP_BREAKPOINT_EN
        ,
        ST_BREAK
`endif
    } state_e;

    // Resting state for a mode when no burst or breakpoint holds the FSM.
    function automatic state_e idle_state(input mode_e m);
        case (m)
            MODE_RUN:  return ST_RUN;
            MODE_STEP: return ST_STEP;
            default:   return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/step_debounce.sv
// Step button conditioning: 2-flop synchronizer, stable-sample debouncer and
// a one-cycle pulse on each rising edge of the debounced level.
module step_debounce
    import cycle_step_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic step_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_inc;
    logic          pulse_q;
    logic          pulse_d;

    // The count only advances while the synchronized sample disagrees with the
    // accepted level; any agreeing sample (a bounce) drops it back to zero.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        cnt_inc = cnt_q + CW'(1);
        if (sync2_q != level_q) begin
            if (cnt_inc == CW'(DEBOUNCE_CYC)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_inc;
            end
        end
        pulse_d = level_d & ~level_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign step_pulse = pulse_q;

endmodule

// File: rtl/cycle_step_ctrl.sv
// Clock-enable controller: halt, free-run, debounced single-step and N-cycle burst.
// Define STEP_BREAKPOINT_EN to add the pc/bp_addr breakpoint and sticky bp_hit.
module cycle_step_ctrl
    import cycle_step_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int DEBOUNCE_CYC = 4,
    parameter int PC_W         = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           mode,
    input  logic                 step_btn,
    input  logic [CNT_W-1:0]     burst_len,
    input  logic                 start,
`ifdef STEP_BREAKPOINT_EN
    input  logic [PC_W-1:0]      pc,
    input  logic [PC_W-1:0]      bp_addr,
    input  logic                 bp_valid,
    output logic                 bp_hit,
`endif
    output logic                 cpu_en,
    output logic                 busy,
    output logic                 done,
    output logic [CYC_CNT_W-1:0] cycle_count
);

    mode_e                mode_s;
    mode_e                mode_q;
    mode_e                mode_d;
    state_e               state_q;
    state_e               state_d;
    logic                 cpu_en_q;
    logic                 cpu_en_d;
    logic                 busy_q;
    logic                 busy_d;
    logic                 done_q;
    logic                 done_d;
    logic [CNT_W-1:0]     rem_q;
    logic [CNT_W-1:0]     rem_d;
    logic [CYC_CNT_W-1:0] cyc_q;
    logic [CYC_CNT_W-1:0] cyc_d;
    logic                 step_pulse;
`ifdef STEP_BREAKPOINT_EN
    logic                 bp_hit_q;
    logic                 bp_hit_d;
`endif

    assign mode_s = mode_e'(mode);

    step_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (step_btn),
        .step_pulse(step_pulse)
    );

    // A burst launches only if BURST was already the mode on the previous
    // edge, so a start arriving together with the mode switch is dropped.
    always_comb begin
        state_d  = idle_state(mode_s);
        mode_d   = mode_s;
        cpu_en_d = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        rem_d    = rem_q;
        cyc_d    = cyc_q + CYC_CNT_W'(cpu_en_q);
`ifdef STEP_BREAKPOINT_EN
        bp_hit_d = bp_hit_q;
`endif
        case (state_q)
            ST_BURST: begin
                if (mode_s == MODE_BURST) begin
                    if (rem_q == '0) begin
                        done_d = 1'b1;
                    end else begin
                        rem_d    = rem_q - CNT_W'(1);
                        cpu_en_d = 1'b1;
                        busy_d   = 1'b1;
                        state_d  = ST_BURST;
                    end
                end
            end
`ifdef STEP_BREAKPOINT_EN
            ST_BREAK: begin
                if (mode_s == MODE_HALT) begin
                    bp_hit_d = 1'b0;
                end else begin
                    state_d = ST_BREAK;
                end
            end
`endif
            default: begin
                case (mode_s)
                    MODE_RUN:  cpu_en_d = 1'b1;
                    MODE_STEP: cpu_en_d = step_pulse;
                    MODE_BURST: begin
                        if (start && (mode_q == MODE_BURST)) begin
                            if (burst_len == '0) begin
                                done_d = 1'b1;
                            end else begin
                                rem_d    = burst_len - CNT_W'(1);
                                cpu_en_d = 1'b1;
                                busy_d   = 1'b1;
                                state_d  = ST_BURST;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        endcase
`ifdef STEP_BREAKPOINT_EN
        // A hit on an executed cycle overrides every other outcome, including a pending done.
        if (cpu_en_q && bp_valid && (pc == bp_addr)) begin
            state_d  = ST_BREAK;
            cpu_en_d = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            bp_hit_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_HALT;
            cpu_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rem_q    <= '0;
            cyc_q    <= '0;
`ifdef STEP_BREAKPOINT_EN
            bp_hit_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            cpu_en_q <= cpu_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rem_q    <= rem_d;
            cyc_q    <= cyc_d;
`ifdef STEP_BREAKPOINT_EN
            bp_hit_q <= bp_hit_d;
`endif
        end
    end

    assign cpu_en      = cpu_en_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign cycle_count = cyc_q;
`ifdef STEP_BREAKPOINT_EN
    assign bp_hit      = bp_hit_q;
`endif

endmodule

// File: tb/tb_cycle_step_ctrl.sv
// Directed bench for cycle_step_ctrl: reset, free-run, debounced step, burst,
// abort, and the breakpoint sequence when STEP_BREAKPOINT_EN is defined.
module tb_cycle_step_ctrl;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       mode;
    logic             step_btn;
    logic [CNT_W-1:0] burst_len;
    logic             start;
    logic             cpu_en;
    logic             busy;
    logic             done;
    logic [31:0]      cycle_count;
`ifdef STEP_BREAKPOINT_EN
    logic [31:0]      pc;
    logic [31:0]      bp_addr;
    logic             bp_valid;
    logic             bp_hit;

    assign pc = cycle_count << 2;
`endif

    int pass_cnt  = 0;
    int check_cnt = 0;
    int en_seen;
    int done_seen;
    int pulse_idx;
    logic [6:0] exp_en;
    logic [6:0] exp_done;

    always #5 clk = ~clk;

    cycle_step_ctrl #(
        .CNT_W       (CNT_W),
        .DEBOUNCE_CYC(4),
        .PC_W        (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .step_btn   (step_btn),
        .burst_len  (burst_len),
        .start      (start),
`ifdef STEP_BREAKPOINT_EN
        .pc         (pc),
        .bp_addr    (bp_addr),
        .bp_valid   (bp_valid),
        .bp_hit     (bp_hit),
`endif
        .cpu_en     (cpu_en),
        .busy       (busy),
        .done       (done),
        .cycle_count(cycle_count)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    initial begin
        rst       = 1'b1;
        mode      = 2'b00;
        step_btn  = 1'b0;
        burst_len = '0;
        start     = 1'b0;
`ifdef STEP_BREAKPOINT_EN
        bp_valid  = 1'b0;
        bp_addr   = 32'h10;
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Run briefly, then reset mid-operation
        mode = 2'b01;
        repeat (5) @(negedge clk);
        checkOutput("pre_rst_en", 32'(cpu_en), 1);
        checkOutput("pre_rst_cc", cycle_count, 4);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rst_en", 32'(cpu_en), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_cc", cycle_count, 0);
        rst  = 1'b0;
        mode = 2'b00;
        @(negedge clk);

        // Free-run for 10 cycles
        checkOutput("run_pre_en", 32'(cpu_en), 0);
        mode    = 2'b01;
        en_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            en_seen += int'(cpu_en);
        end
        mode = 2'b00;
        @(negedge clk);
        checkOutput("run_stop_en", 32'(cpu_en), 0);
        checkOutput("run_cc", cycle_count, 10);
        repeat (3) begin
            @(negedge clk);
            en_seen += int'(cpu_en);
        end
        checkOutput("run_en_total", 32'(en_seen), 10);

        // Step mode: short glitch must not step
        mode = 2'b10;
        @(negedge clk);
        step_btn = 1'b1;
        repeat (2) @(negedge clk);
        step_btn = 1'b0;
        en_seen  = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            en_seen += int'(cpu_en);
        end
        checkOutput("step_glitch", 32'(en_seen), 0);

        // Held press: one pulse in the cycle after edge k+6
        step_btn  = 1'b1;
        en_seen   = 0;
        pulse_idx = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cpu_en) begin
                en_seen++;
                if (pulse_idx < 0) pulse_idx = i;
            end
        end
        checkOutput("step_pulses", 32'(en_seen), 1);
        checkOutput("step_latency", 32'(pulse_idx), 6);
        checkOutput("step_cc", cycle_count, 11);

        // Release never steps
        step_btn = 1'b0;
        en_seen  = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            en_seen += int'(cpu_en);
        end
        checkOutput("step_release", 32'(en_seen), 0);
        checkOutput("step_rel_cc", cycle_count, 11);

        // Burst of 5 with a stray start during the burst
        mode = 2'b11;
        @(negedge clk);
        burst_len = 16'd5;
        start     = 1'b1;
        exp_en    = 7'b0011111;
        exp_done  = 7'b0100000;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            checkOutput($sformatf("burst_en_%0d", i), 32'(cpu_en), 32'(exp_en[i]));
            checkOutput($sformatf("burst_busy_%0d", i), 32'(busy), 32'(exp_en[i]));
            checkOutput($sformatf("burst_done_%0d", i), 32'(done), 32'(exp_done[i]));
            start = (i == 1);
        end
        checkOutput("burst_cc", cycle_count, 16);

        // Start together with the switch into BURST is dropped
        mode = 2'b00;
        @(negedge clk);
        mode      = 2'b11;
        burst_len = 16'd3;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("simul_busy", 32'(busy), 0);
        checkOutput("simul_en", 32'(cpu_en), 0);
        @(negedge clk);
        checkOutput("simul_busy2", 32'(busy), 0);
        checkOutput("simul_done", 32'(done), 0);

        // Zero-length burst: done only
        burst_len = '0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("len0_done", 32'(done), 1);
        checkOutput("len0_en", 32'(cpu_en), 0);
        checkOutput("len0_busy", 32'(busy), 0);
        @(negedge clk);
        checkOutput("len0_done_clr", 32'(done), 0);
        checkOutput("len0_cc", cycle_count, 16);

        // Abort a burst of 8 after the third enabled cycle
        burst_len = 16'd8;
        start     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b0;
            checkOutput($sformatf("abort_en_%0d", i), 32'(cpu_en), 1);
        end
        mode = 2'b00;
        @(negedge clk);
        checkOutput("abort_en", 32'(cpu_en), 0);
        checkOutput("abort_busy", 32'(busy), 0);
        done_seen = int'(done);
        repeat (10) begin
            @(negedge clk);
            done_seen += int'(done);
        end
        checkOutput("abort_no_done", 32'(done_seen), 0);
        checkOutput("abort_cc", cycle_count, 19);

        // Start outside BURST mode is ignored
        burst_len = 16'd4;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("halt_start_busy", 32'(busy), 0);
        checkOutput("halt_start_en", 32'(cpu_en), 0);

`ifdef STEP_BREAKPOINT_EN
        // Breakpoint at pc 0x10 while free-running
        rst = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        bp_valid = 1'b1;
        mode     = 2'b01;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput($sformatf("bp_en_%0d", i), 32'(cpu_en), 32'(i < 5));
        end
        checkOutput("bp_hit", 32'(bp_hit), 1);
        checkOutput("bp_cc", cycle_count, 5);
        mode = 2'b00;
        @(negedge clk);
        checkOutput("bp_clear", 32'(bp_hit), 0);
        checkOutput("bp_halt_en", 32'(cpu_en), 0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
